// File: rtl/syn_fifo_v2.sv
// syn_fifo_v2: single-clock FIFO with one-cycle registered read data and
// occupancy flags derived from the registered count.
// Optional feature macro: SYN_FIFO_V2_ERR_EN compiles in sticky overflow/underflow
// tracking. When it is undefined, overflow/underflow are tied low and err_clr is ignored.
module syn_fifo_v2 #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     w_en,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     r_en,
  output logic [WIDTH-1:0]         r_data,
  output logic                     r_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers and count share one width: address bits plus a wrap bit.
  typedef logic [AW:0] ptr_t;

  localparam ptr_t PtrOne   = ptr_t'(1);
  localparam ptr_t DepthCnt = ptr_t'(DEPTH);
  localparam ptr_t AfCnt    = ptr_t'(AF_LEVEL);
  localparam ptr_t AeCnt    = ptr_t'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             count_q, count_d;
  logic [WIDTH-1:0] r_data_q;
  logic             r_valid_q;

  logic             rd_acc;
  logic             wr_acc;

  // Request acceptance and next-state for pointers and occupancy.
  always_comb begin
    rd_acc   = r_en && (count_q != '0);
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc   = w_en && ((count_q != DepthCnt) || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, count and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      r_valid_q <= rd_acc;
      if (rd_acc) begin
        r_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  // Storage array; not cleared by reset, only gated so reset wins over a write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= w_data;
    end
  end

`ifdef SYN_FIFO_V2_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (w_en && !wr_acc) begin
        overflow_q <= 1'b1;
      end else if (err_clr) begin
        overflow_q <= 1'b0;
      end
      if (r_en && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end else if (err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthCnt);
  assign almost_full  = (count_q >= AfCnt);
  assign almost_empty = (count_q <= AeCnt);
  assign r_data       = r_data_q;
  assign r_valid      = r_valid_q;

endmodule

// File: doc/syn_fifo_v2.md
SYN_FIFO_V2 -- requirements
Module: syn_fifo_v2

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold; range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold; range 0..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port w_data  input  WIDTH  write data.
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port full  output  1  no free entries.
REQ-010 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-011 SHALL have port r_en  input  1  read request.
REQ-012 SHALL have port r_data  output  WIDTH  registered read data.
REQ-013 SHALL have port r_valid  output  1  r_data updated by the read accepted in the previous cycle.
REQ-014 SHALL have port empty  output  1  no stored entries.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 SHALL have ports overflow, underflow (output, 1) and err_clr (input, 1); see Configuration.

Function
REQ-018 SHALL use write/read pointers of $clog2(DEPTH)+1 bits, wrapping DEPTH-1 -> 0 in address bits with the MSB toggling on wrap.
REQ-019 SHALL accept a write when w_en && (!full || read accepted in the same cycle); accepted data stored at write address, write pointer +1.
REQ-020 SHALL accept a read when r_en && !empty; r_data <= entry at read address, read pointer +1, r_valid = 1 next cycle, else r_valid = 0 and r_data holds.
REQ-021 SHALL give read latency of exactly 1 cycle from accepted r_en to r_data/r_valid.
REQ-022 SHALL, when empty and w_en && r_en both asserted, accept the write and reject the read (no fall-through).
REQ-023 SHALL, when full and w_en && r_en both asserted, accept both; count stays DEPTH, full stays 1.
REQ-024 SHALL update count +1 for write-only, -1 for read-only, unchanged for both or neither.
REQ-025 SHALL derive empty (count==0), full (count==DEPTH), almost_full, almost_empty from registered state only; flags valid the cycle after the causing edge, no combinational path from w_en/r_en.
REQ-026 SHALL ignore rejected requests: no pointer, count, memory or r_data change.

Reset
REQ-027 SHALL, with rst high at a rising edge, set pointers 0, count 0, r_data 0, r_valid 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0.
REQ-028 SHALL give rst priority over all requests in the same cycle; stored contents discarded, memory array not cleared.
REQ-029 SHALL accept a write on the first edge after rst deasserts.

Configuration
REQ-030 SHALL use macro SYN_FIFO_V2_ERR_EN to compile in error tracking.
REQ-031 SHALL, with SYN_FIFO_V2_ERR_EN defined, set overflow sticky on w_en rejected (full, no read), underflow sticky on r_en while empty; both cleared by err_clr (set wins if same cycle) or rst.
REQ-032 SHALL, without SYN_FIFO_V2_ERR_EN, keep all ports, drive overflow/underflow constant 0, ignore err_clr, add no error logic.

Verification
REQ-033 SHALL cover: reset, write 0x11,0x22,0x33, then 3 reads -> r_data 0x11,0x22,0x33 each with r_valid one cycle after r_en; empty=1 after.
REQ-034 SHALL cover: DEPTH=8, 8 writes -> full=1, count=8, almost_full=1 from 6th write; 9th write ignored, overflow=1 (ERR_EN), contents unchanged.
REQ-035 SHALL cover: full, w_en&&r_en with 0xAA -> read returns oldest, count stays 8, 0xAA read last after 7 more reads.
REQ-036 SHALL cover: empty, w_en&&r_en with 0x5C -> r_valid=0 next cycle, count=1; next read returns 0x5C.
REQ-037 SHALL cover: 20 write/read pairs (DEPTH=8) -> pointer wrap, data order preserved, count never exceeds 1.
REQ-038 SHALL cover: rst asserted with count=5 and w_en high -> all outputs at reset values next cycle; r_en on empty then sets underflow=1, err_clr clears it.
